meas_sequencer: RTL

Measurement controller for the frequency meter. It sequences the external edge/tick counter: clear, gate enable, count-source select and latch. It schedules the conversion unit (division plus BCD) through a start/done handshake and presents each finished measurement to the display path through a valid/ack handshake. In auto mode it picks direct-frequency or period measurement per cycle from the previous count.

---
 rtl/freq_meter_pkg.sv | 41 ++++
 rtl/sig_edge_sync.sv | 38 +++
 rtl/meas_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter measurement path.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    GATE,
    LATCH,
    CONV,
    HOLD
  } meas_state_e;

  typedef enum logic {
    MODE_FREQ   = 1'b0,
    MODE_PERIOD = 1'b1
  } meas_mode_e;

  typedef enum logic [1:0] {
    REQ_AUTO     = 2'b00,
    REQ_FREQ     = 2'b01,
    REQ_PERIOD   = 2'b10,
    REQ_AUTO_ALT = 2'b11
  } mode_req_e;

  localparam int unsigned DEF_LOW_THRESH  = 10;
  localparam int unsigned DEF_HIGH_THRESH = 1000;

  function automatic logic req_is_auto(input mode_req_e req);
    return (req == REQ_AUTO) || (req == REQ_AUTO_ALT);
  endfunction

  function automatic meas_mode_e resolve_mode(input mode_req_e req, input meas_mode_e auto_mode);
    case (req)
      REQ_FREQ:   return MODE_FREQ;
      REQ_PERIOD: return MODE_PERIOD;
      default:    return auto_mode;
    endcase
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse; the pulse
// appears three clocks after the asynchronous input rises.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: steps the external counter through clear/gate/latch,
// hands counts to the conversion unit and holds each result for the display.
module meas_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_TICKS    = 1600000,
  parameter int unsigned TIMEOUT_TICKS = 32000000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned LOW_THRESH    = DEF_LOW_THRESH,
  parameter int unsigned HIGH_THRESH   = DEF_HIGH_THRESH
) (
  input  logic             clk_16MHZ,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             run,
  input  logic [1:0]       mode_req,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             cnt_ovf,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             cnt_sel,
  output logic             conv_start,
  output logic             conv_mode,
  input  logic             conv_done,
  output logic [CNT_W-1:0] meas_count,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             meas_mode,
  output logic             no_signal,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned TICK_MAX = (GATE_TICKS > TIMEOUT_TICKS) ? GATE_TICKS : TIMEOUT_TICKS;
  localparam int unsigned TW       = $clog2(TICK_MAX + 1);

  localparam logic [TW-1:0]    TICK_SAT     = TW'(TICK_MAX);
  localparam logic [TW-1:0]    GATE_LAST    = TW'(GATE_TICKS - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] LOW_LIM      = CNT_W'(LOW_THRESH);
  localparam logic [CNT_W-1:0] HIGH_LIM     = CNT_W'(HIGH_THRESH);

  meas_state_e      state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  mode_req_e        req_q, req_d;
  meas_mode_e       auto_mode_q, auto_mode_d;
  meas_mode_e       meas_mode_q, meas_mode_d;
  logic [CNT_W-1:0] meas_count_q, meas_count_d;
  logic             overflow_q, overflow_d;
  logic             no_signal_q, no_signal_d;
  logic             sig_rise;

  sig_edge_sync u_sig_sync (
    .clk        (clk_16MHZ),
    .rst        (rst),
    .async_in   (sig_in),
    .rise_pulse (sig_rise)
  );

  always_comb begin
    state_d      = state_q;
    tick_d       = (tick_q == TICK_SAT) ? tick_q : tick_q + 1'b1;
    req_d        = req_q;
    auto_mode_d  = auto_mode_q;
    meas_mode_d  = meas_mode_q;
    meas_count_d = meas_count_q;
    overflow_d   = overflow_q;
    no_signal_d  = no_signal_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          req_d       = mode_req_e'(mode_req);
          meas_mode_d = resolve_mode(mode_req_e'(mode_req), auto_mode_q);
          state_d     = CLEAR;
        end
      end

      CLEAR: begin
        tick_d  = '0;
        state_d = (meas_mode_q == MODE_PERIOD) ? ARM : GATE;
      end

      // ARM and period GATE share the edge-wait; the edge wins over a same-cycle timeout
      ARM, GATE: begin
        if (state_q == GATE && meas_mode_q == MODE_FREQ) begin
          if (tick_q >= GATE_LAST) state_d = LATCH;
        end else if (sig_rise) begin
          tick_d  = '0;
          state_d = (state_q == ARM) ? GATE : LATCH;
        end else if (tick_q >= TIMEOUT_LAST) begin
          no_signal_d  = 1'b1;
          meas_count_d = '0;
          overflow_d   = 1'b0;
          state_d      = HOLD;
        end
      end

      LATCH: begin
        meas_count_d = cnt_val;
        overflow_d   = cnt_ovf;
        no_signal_d  = 1'b0;
        if (req_is_auto(req_q)) begin
          if (meas_mode_q == MODE_FREQ && cnt_val < LOW_LIM)
            auto_mode_d = MODE_PERIOD;
          else if (meas_mode_q == MODE_PERIOD && (cnt_val < HIGH_LIM || cnt_ovf))
            auto_mode_d = MODE_FREQ;
        end
        state_d = CONV;
      end

      CONV: begin
        if (conv_done) state_d = HOLD;
      end

      HOLD: begin
        if (result_ack) begin
          if (run) begin
            meas_mode_d = resolve_mode(req_q, auto_mode_q);
            state_d     = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_16MHZ or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      req_q        <= REQ_AUTO;
      auto_mode_q  <= MODE_FREQ;
      meas_mode_q  <= MODE_FREQ;
      meas_count_q <= '0;
      overflow_q   <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      req_q        <= req_d;
      auto_mode_q  <= auto_mode_d;
      meas_mode_q  <= meas_mode_d;
      meas_count_q <= meas_count_d;
      overflow_q   <= overflow_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign cnt_clr      = (state_q == CLEAR);
  assign cnt_en       = (state_q == GATE);
  assign conv_start   = (state_q == LATCH);
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign cnt_sel      = meas_mode_q;
  assign conv_mode    = meas_mode_q;
  assign meas_mode    = meas_mode_q;
  assign meas_count   = meas_count_q;
  assign overflow     = overflow_q;
  assign no_signal    = no_signal_q;

endmodule
